sequence_recorder_16x4: RTL and testbench



---
 rtl/sequence_recorder_16x4_pkg.sv | 30 +++
 rtl/sequence_recorder_16x4_sync_ram_16x4.sv | 41 ++++
 rtl/sequence_recorder_16x4.sv | 153 +++++++++++++++
 tb/tb_sequence_recorder_16x4.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_recorder_16x4_pkg.sv
// sequence_recorder_16x4_pkg
//   Shared definitions for the sequence recorder: FSM state encoding,
//   one-hot colour codes used by the memory game, RAM geometry and the
//   default timeout length.
package sequence_recorder_16x4_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    SOLTA   = 3'd1,
    ESPERA  = 3'd2,
    FIM     = 3'd3,
    ERRO    = 3'd4
  } estado_t;

  localparam logic [3:0] AZUL     = 4'b0001;
  localparam logic [3:0] VERDE    = 4'b0010;
  localparam logic [3:0] AMARELO  = 4'b0100;
  localparam logic [3:0] VERMELHO = 4'b1000;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  localparam int TIMEOUT_CICLOS_PADRAO = 1000;

  // True when exactly one button is pressed.
  function automatic logic eh_one_hot(input logic [3:0] b);
    return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sequence_recorder_16x4_sync_ram_16x4.sv
// sync_ram_16x4
//   16-word synchronous RAM with one write port and one registered read
//   port. A read and a write to the same address on the same edge return
//   the old word (read-before-write). Storage is not reset; only the read
//   register is cleared by reset.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset (read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - registered read data, mem[raddr] from the previous edge
module sync_ram_16x4
  import sequence_recorder_16x4_pkg::*;
#(
  parameter int DATA_W = sequence_recorder_16x4_pkg::DATA_W,
  parameter int ADDR_W = sequence_recorder_16x4_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read of mem gives the pre-write word on a collision.
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/sequence_recorder_16x4.sv
// sequence_recorder_16x4
//   Records the player's one-hot button presses, in order, into a 16x4
//   synchronous RAM and exposes a read port addressed and timed like the
//   game's sequence ROM (1-cycle registered read).
//   Optional build macro TIMEOUT_EN adds an ESPERA inactivity timeout and
//   the timeout output.
// Ports:
//   clock            - system clock
//   reset            - synchronous active-high reset
//   iniciar          - start a new recording (INICIAL/FIM/ERRO only)
//   botoes           - button levels, one bit per colour
//   ultimo_endereco  - address of last move to record, sampled on start
//   endereco_leitura - read address
//   dado_lido        - registered read data
//   contagem         - number of moves recorded (0..16)
//   gravando         - high while recording (SOLTA, ESPERA)
//   pronto           - high in FIM
//   erro             - high in ERRO
//   timeout          - (TIMEOUT_EN only) ERRO was entered by timeout
module sequence_recorder_16x4
  import sequence_recorder_16x4_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [3:0]  botoes,
  input  logic [3:0]  ultimo_endereco,
  input  logic [3:0]  endereco_leitura,
  output logic [3:0]  dado_lido,
  output logic [4:0]  contagem,
  output logic        gravando,
  output logic        pronto,
`ifdef TIMEOUT_EN
  output logic        erro,
  output logic        timeout
`else
  output logic        erro
`endif
);

  estado_t    estado;
  logic [3:0] limite;
  logic       pressao_valida;
  logic       we;

  assign pressao_valida = eh_one_hot(botoes);
  // The write happens on the same edge the press is accepted.
  assign we = (estado == ESPERA) && pressao_valida;

  sync_ram_16x4 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (contagem[3:0]),
    .wdata (botoes),
    .raddr (endereco_leitura),
    .rdata (dado_lido)
  );

`ifdef TIMEOUT_EN
  localparam logic [15:0] ULTIMO_CICLO = 16'(TIMEOUT_CICLOS - 1);
  logic [15:0] ciclos;
`else
  // The parameter stays on the interface so both builds share instantiations.
  logic unused_timeout_ciclos;
  assign unused_timeout_ciclos = ^TIMEOUT_CICLOS;
`endif

  // limite is only meaningful after a start, so it is left out of reset.
  always_ff @(posedge clock) begin
    if ((estado == INICIAL || estado == FIM || estado == ERRO) && iniciar)
      limite <= ultimo_endereco;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      contagem <= '0;
      gravando <= 1'b0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
`ifdef TIMEOUT_EN
      timeout  <= 1'b0;
      ciclos   <= '0;
`endif
    end else begin
      case (estado)
        INICIAL, FIM, ERRO: begin
          if (iniciar) begin
            estado   <= SOLTA;
            contagem <= '0;
            gravando <= 1'b1;
            pronto   <= 1'b0;
            erro     <= 1'b0;
`ifdef TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end

        // Wait for all buttons released so a held press counts once.
        SOLTA: begin
          if (botoes == 4'b0000) begin
            estado <= ESPERA;
`ifdef TIMEOUT_EN
            ciclos <= '0;
`endif
          end
        end

        ESPERA: begin
          if (pressao_valida) begin
            contagem <= contagem + 5'd1;
            if (contagem[3:0] == limite) begin
              estado   <= FIM;
              gravando <= 1'b0;
              pronto   <= 1'b1;
            end else begin
              estado <= SOLTA;
            end
          end else if (botoes != 4'b0000) begin
            estado   <= ERRO;
            gravando <= 1'b0;
            erro     <= 1'b1;
          end
`ifdef TIMEOUT_EN
          else if (ciclos == ULTIMO_CICLO) begin
            estado   <= ERRO;
            gravando <= 1'b0;
            erro     <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            ciclos <= ciclos + 16'd1;
          end
`endif
        end

        default: begin
          estado   <= INICIAL;
          gravando <= 1'b0;
          pronto   <= 1'b0;
          erro     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_recorder_16x4.sv
// tb_sequence_recorder_16x4
//   Directed bench for sequence_recorder_16x4. Stimulus pushes expected
//   output values into a queue; a monitor on the falling edge pops and
//   compares them against the DUT.
//   Build with TIMEOUT_EN defined to also exercise the timeout path.
module tb_sequence_recorder_16x4;
  import sequence_recorder_16x4_pkg::*;

`ifdef TIMEOUT_EN
  localparam int TCYC = 50;
`else
  localparam int TCYC = TIMEOUT_CICLOS_PADRAO;
`endif

  localparam int S_DADO = 0, S_CONT = 1, S_GRAV = 2, S_PRONTO = 3,
                 S_ERRO = 4, S_TIMEOUT = 5;

  typedef struct {
    int         sig;
    logic [4:0] esperado;
    string      nome;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] ultimo_endereco;
  logic [3:0] endereco_leitura;
  logic [3:0] dado_lido;
  logic [4:0] contagem;
  logic       gravando;
  logic       pronto;
  logic       erro;
`ifdef TIMEOUT_EN
  logic       timeout;
`endif

  exp_t fila[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  sequence_recorder_16x4 #(.TIMEOUT_CICLOS(TCYC)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .botoes           (botoes),
    .ultimo_endereco  (ultimo_endereco),
    .endereco_leitura (endereco_leitura),
    .dado_lido        (dado_lido),
    .contagem         (contagem),
    .gravando         (gravando),
    .pronto           (pronto),
`ifdef TIMEOUT_EN
    .erro             (erro),
    .timeout          (timeout)
`else
    .erro             (erro)
`endif
  );

  function automatic logic [4:0] ler_sinal(input int s);
    case (s)
      S_DADO:    return {1'b0, dado_lido};
      S_CONT:    return contagem;
      S_GRAV:    return {4'b0, gravando};
      S_PRONTO:  return {4'b0, pronto};
      S_ERRO:    return {4'b0, erro};
`ifdef TIMEOUT_EN
      S_TIMEOUT: return {4'b0, timeout};
`endif
      default:   return 5'h1f;
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clock) begin
    while (fila.size() > 0) begin
      exp_t e;
      logic [4:0] v;
      e = fila.pop_front();
      v = ler_sinal(e.sig);
      n_cmp++;
      if (v !== e.esperado) begin
        n_bad++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", e.nome, v, e.esperado, $time);
      end
    end
  end

  task automatic espera(input logic [4:0] v, input int s, input string nome);
    exp_t e;
    e.sig = s; e.esperado = v; e.nome = nome;
    fila.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Start a recording and advance to ESPERA.
  task automatic iniciar_gravacao(input logic [3:0] lim);
    ultimo_endereco = lim;
    iniciar = 1'b1;
    step(1);
    espera(5'd1, S_GRAV,   "start_gravando");
    espera(5'd0, S_CONT,   "start_contagem");
    espera(5'd0, S_ERRO,   "start_erro");
    espera(5'd0, S_PRONTO, "start_pronto");
`ifdef TIMEOUT_EN
    espera(5'd0, S_TIMEOUT, "start_timeout");
`endif
    iniciar = 1'b0;
    step(1);
  endtask

  task automatic apertar(input logic [3:0] b, input logic [4:0] cont, input logic fim);
    botoes = b;
    step(1);
    espera(cont, S_CONT, "press_contagem");
    espera({4'b0, fim}, S_PRONTO, "press_pronto");
    espera({4'b0, ~fim}, S_GRAV, "press_gravando");
    botoes = 4'b0000;
    step(1);
  endtask

  task automatic ler(input logic [3:0] a, input logic [3:0] d, input string nome);
    endereco_leitura = a;
    step(1);
    espera({1'b0, d}, S_DADO, nome);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; botoes = 4'b0;
    ultimo_endereco = 4'b0; endereco_leitura = 4'b0;
    step(3);
    espera(5'd0, S_DADO,   "rst_dado");
    espera(5'd0, S_CONT,   "rst_contagem");
    espera(5'd0, S_GRAV,   "rst_gravando");
    espera(5'd0, S_PRONTO, "rst_pronto");
    espera(5'd0, S_ERRO,   "rst_erro");
`ifdef TIMEOUT_EN
    espera(5'd0, S_TIMEOUT, "rst_timeout");
`endif
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      espera(5'd0, S_CONT,   "idle_contagem");
      espera(5'd0, S_GRAV,   "idle_gravando");
      espera(5'd0, S_PRONTO, "idle_pronto");
      espera(5'd0, S_ERRO,   "idle_erro");
    end

    // Four moves, limit 3.
    iniciar_gravacao(4'd3);
    apertar(AZUL,     5'd1, 1'b0);
    apertar(VERDE,    5'd2, 1'b0);
    apertar(AMARELO,  5'd3, 1'b0);
    apertar(VERMELHO, 5'd4, 1'b1);
    ler(4'd0, AZUL,     "rd4_a0");
    ler(4'd1, VERDE,    "rd4_a1");
    ler(4'd2, AMARELO,  "rd4_a2");
    ler(4'd3, VERMELHO, "rd4_a3");

    // Held button counts once; collision read returns the old word.
    iniciar_gravacao(4'd1);
    endereco_leitura = 4'd0;
    botoes = VERDE;
    step(1);
    espera({1'b0, AZUL}, S_DADO, "rbw_old");
    espera(5'd1, S_CONT, "hold_contagem");
    step(1);
    espera({1'b0, VERDE}, S_DADO, "rbw_new");
    for (int i = 0; i < 18; i++) begin
      step(1);
      espera(5'd1, S_CONT, "hold_contagem");
    end
    botoes = 4'b0;
    step(1);
    apertar(AMARELO, 5'd2, 1'b1);
    ler(4'd0, VERDE,   "hold_a0");
    ler(4'd1, AMARELO, "hold_a1");
    ler(4'd2, AMARELO, "hold_a2_untouched");

    // Two buttons at once -> ERRO, no write.
    iniciar_gravacao(4'd3);
    apertar(VERMELHO, 5'd1, 1'b0);
    botoes = 4'b0110;
    step(1);
    espera(5'd1, S_ERRO, "multi_erro");
    espera(5'd0, S_GRAV, "multi_gravando");
    espera(5'd1, S_CONT, "multi_contagem");
    botoes = 4'b0;
    ler(4'd1, AMARELO, "multi_no_write");

    // Restart from ERRO with limit 15: 16 moves, then a 17th ignored.
    iniciar_gravacao(4'hF);
    for (int i = 0; i < 16; i++)
      apertar(4'(1 << (i % 4)), 5'(i + 1), (i == 15));
    botoes = VERMELHO;
    step(1);
    espera(5'd16, S_CONT, "extra_contagem");
    espera(5'd1, S_PRONTO, "extra_pronto");
    botoes = 4'b0;
    for (int a = 0; a < 16; a++)
      ler(4'(a), 4'(1 << (a % 4)), "full_rd");

`ifdef TIMEOUT_EN
    // No press: ERRO exactly TCYC cycles after entering ESPERA.
    iniciar_gravacao(4'd3);
    step(TCYC - 1);
    espera(5'd0, S_ERRO, "to_before");
    step(1);
    espera(5'd1, S_ERRO,    "to_erro");
    espera(5'd1, S_TIMEOUT, "to_timeout");
    espera(5'd0, S_CONT,    "to_contagem");
    iniciar_gravacao(4'd3);
`endif

    // Reset mid-recording; written words persist.
    iniciar_gravacao(4'd3);
    apertar(VERMELHO, 5'd1, 1'b0);
    reset = 1'b1;
    step(1);
    espera(5'd0, S_CONT,   "midrst_contagem");
    espera(5'd0, S_GRAV,   "midrst_gravando");
    espera(5'd0, S_PRONTO, "midrst_pronto");
    reset = 1'b0;
    ler(4'd0, VERMELHO, "midrst_persist");

    step(2);
    n_cmp++;
    if (fila.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
